mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_rr.sv | 15 +
 rtl/mem_arb.sv | 166 ++++++++++++++++
 tb/tb_mem_arb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-client memory arbiter.
//   state_t  - arbiter FSM states
//   OP_RD/WR - request opcode encodings
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational 2-way round-robin picker.
//   req - per-client request bits
//   ptr - client that has priority this round
//   win - one-hot winner (0 when nobody requests)
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb begin
    win = 2'b00;
    if (ptr == 1'b0) win = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
    else             win = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
  end
endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates two burst clients onto one memory port.
//   clock/reset        - rising-edge clock, synchronous active-low reset
//   cN_req_*           - client request channel (valid/ready, opcode, len, addr)
//   cN_wr_*            - client write-beat channel
//   cN_rd_*            - client read-beat channel
//   mem_req_*/mem_wr_* - request and write beats toward memory
//   mem_rd_*           - read beats from memory
//   busy/grant         - transaction in progress / one-hot owner
// Only request fields and the beat counter are registered; beat data is muxed
// straight through to/from the owner.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     c0_req_valid,
  input  logic                     c0_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
  output logic                     c0_req_ready,
  input  logic                     c0_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
  output logic                     c0_wr_ready,
  output logic                     c0_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
  input  logic                     c0_rd_ready,
  input  logic                     c1_req_valid,
  input  logic                     c1_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
  output logic                     c1_req_ready,
  input  logic                     c1_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
  output logic                     c1_wr_ready,
  output logic                     c1_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
  input  logic                     c1_rd_ready,
  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  output logic                     mem_rd_ready,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     busy,
  output logic [1:0]               grant
);
  state_t                   state;
  logic [1:0]               gnt;
  logic                     ptr;
  logic                     op_q;
  logic [MEM_LEN_BITS-1:0]  len_q;
  logic [MEM_LEN_BITS-1:0]  cnt;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [1:0]               win;
  logic                     own_rd_ready;
  logic                     own_wr_valid;
  logic                     beat;

  mem_arb_rr u_rr (
    .req ({c1_req_valid, c0_req_valid}),
    .ptr (ptr),
    .win (win)
  );

  assign own_rd_ready = gnt[1] ? c1_rd_ready : c0_rd_ready;
  assign own_wr_valid = gnt[1] ? c1_wr_valid : c0_wr_valid;
  // Write beats need no ready from memory: the owner's valid alone counts.
  assign beat = ((state == RD) && mem_rd_valid && own_rd_ready) ||
                ((state == WR) && own_wr_valid);

  // Outputs are forced low while reset is held so a mid-burst reset cannot
  // leak a beat during the reset cycle itself.
  always_comb begin
    c0_req_ready   = 1'b0;
    c1_req_ready   = 1'b0;
    c0_wr_ready    = 1'b0;
    c1_wr_ready    = 1'b0;
    c0_rd_valid    = 1'b0;
    c1_rd_valid    = 1'b0;
    c0_rd_bits     = '0;
    c1_rd_bits     = '0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;
    busy           = 1'b0;
    grant          = 2'b00;
    if (reset) begin
      busy  = (state != IDLE);
      grant = gnt;
      case (state)
        IDLE: begin
          c0_req_ready = win[0];
          c1_req_ready = win[1];
        end
        ISSUE: begin
          mem_req_valid  = 1'b1;
          mem_req_opcode = op_q;
          mem_req_len    = len_q;
          mem_req_addr   = addr_q;
        end
        RD: begin
          mem_rd_ready = own_rd_ready;
          c0_rd_valid  = gnt[0] && mem_rd_valid;
          c1_rd_valid  = gnt[1] && mem_rd_valid;
          c0_rd_bits   = gnt[0] ? mem_rd_bits : '0;
          c1_rd_bits   = gnt[1] ? mem_rd_bits : '0;
        end
        WR: begin
          c0_wr_ready  = gnt[0];
          c1_wr_ready  = gnt[1];
          mem_wr_valid = own_wr_valid;
          mem_wr_bits  = gnt[1] ? c1_wr_bits : c0_wr_bits;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= 2'b00;
      ptr    <= 1'b0;
      cnt    <= '0;
      op_q   <= OP_RD;
      len_q  <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: if (|win) begin
          gnt    <= win;
          op_q   <= win[1] ? c1_req_opcode : c0_req_opcode;
          len_q  <= win[1] ? c1_req_len    : c0_req_len;
          addr_q <= win[1] ? c1_req_addr   : c0_req_addr;
          state  <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= (op_q == OP_WR) ? WR : RD;
        end
        RD, WR: if (beat) begin
          if (cnt == len_q) begin
            // Priority passes to whichever client did not just finish.
            ptr   <= gnt[0];
            gnt   <= 2'b00;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic        c0_req_valid, c0_req_opcode, c0_req_ready;
  logic [7:0]  c0_req_len;
  logic [31:0] c0_req_addr;
  logic        c0_wr_valid, c0_wr_ready, c0_rd_valid, c0_rd_ready;
  logic [63:0] c0_wr_bits, c0_rd_bits;
  logic        c1_req_valid, c1_req_opcode, c1_req_ready;
  logic [7:0]  c1_req_len;
  logic [31:0] c1_req_addr;
  logic        c1_wr_valid, c1_wr_ready, c1_rd_valid, c1_rd_ready;
  logic [63:0] c1_wr_bits, c1_rd_bits;
  logic        mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_ready, mem_rd_valid;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_wr_bits, mem_rd_bits;
  logic        busy;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_arb dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_opcode(c0_req_opcode), .c0_req_len(c0_req_len),
    .c0_req_addr(c0_req_addr), .c0_req_ready(c0_req_ready),
    .c0_wr_valid(c0_wr_valid), .c0_wr_bits(c0_wr_bits), .c0_wr_ready(c0_wr_ready),
    .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits), .c0_rd_ready(c0_rd_ready),
    .c1_req_valid(c1_req_valid), .c1_req_opcode(c1_req_opcode), .c1_req_len(c1_req_len),
    .c1_req_addr(c1_req_addr), .c1_req_ready(c1_req_ready),
    .c1_wr_valid(c1_wr_valid), .c1_wr_bits(c1_wr_bits), .c1_wr_ready(c1_wr_ready),
    .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits), .c1_rd_ready(c1_rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits),
    .busy(busy), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 0;
    c0_wr_valid = 0; c0_wr_bits = 0; c0_rd_ready = 0;
    c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 0;
    c1_wr_valid = 0; c1_wr_bits = 0; c1_rd_ready = 0;
    mem_rd_valid = 0; mem_rd_bits = 0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_memreq", mem_req_valid, 0);
    reset = 1'b1;

    // c0 read len=3 addr=0x100 alone
    tick;
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 3; c0_req_addr = 32'h100;
    settle;
    chk("t1_c0_ready", c0_req_ready, 1);
    chk("t1_c1_ready", c1_req_ready, 0);
    chk("t1_busy_idle", busy, 0);
    tick;
    c0_req_valid = 0;
    settle;
    chk("t1_memreq", mem_req_valid, 1);
    chk("t1_addr", mem_req_addr, 64'h100);
    chk("t1_len", mem_req_len, 3);
    chk("t1_op", mem_req_opcode, 0);
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_ready_drop", c0_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      mem_rd_valid = 1; mem_rd_bits = 64'hA0 + 64'(i); c0_rd_ready = 1;
      settle;
      chk("t1_rd_valid", c0_rd_valid, 1);
      chk("t1_rd_bits", c0_rd_bits, 64'hA0 + 64'(i));
      chk("t1_c1_rd_valid", c1_rd_valid, 0);
      chk("t1_memreq_once", mem_req_valid, 0);
      chk("t1_grant_hold", grant, 2'b01);
    end
    tick;
    mem_rd_valid = 0; c0_rd_ready = 0;
    settle;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_grant", grant, 0);

    // c0 finished last, so c1 now has priority
    c0_req_valid = 1; c1_req_valid = 1;
    settle;
    chk("rr_c1_ready", c1_req_ready, 1);
    chk("rr_c0_ready", c0_req_ready, 0);
    tick;
    c0_req_valid = 0; c1_req_valid = 0;
    settle;
    chk("rr_grant", grant, 2'b10);
    // reset from ISSUE
    reset = 0;
    tick;
    reset = 1;
    settle;
    chk("rr_rst_busy", busy, 0);

    // simultaneous after reset: c0 read len=1, c1 write len=0
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 1; c0_req_addr = 32'h40;
    c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 0; c1_req_addr = 32'h200;
    settle;
    chk("t2_c0_first", c0_req_ready, 1);
    chk("t2_c1_wait", c1_req_ready, 0);
    tick;
    c0_req_valid = 0;
    settle;
    chk("t2_c1_issue_wait", c1_req_ready, 0);
    chk("t2_addr", mem_req_addr, 64'h40);
    for (int i = 0; i < 2; i++) begin
      tick;
      mem_rd_valid = 1; mem_rd_bits = 64'h55; c0_rd_ready = 1;
      settle;
      chk("t2_c1_rd_wait", c1_req_ready, 0);
    end
    tick;
    mem_rd_valid = 0; c0_rd_ready = 0;
    settle;
    chk("t2_c1_ready", c1_req_ready, 1);
    chk("t2_idle_busy", busy, 0);
    tick;
    c1_req_valid = 0;
    settle;
    chk("t3_memreq", mem_req_valid, 1);
    chk("t3_op", mem_req_opcode, 1);
    chk("t3_addr", mem_req_addr, 64'h200);
    chk("t3_grant", grant, 2'b10);
    tick;
    c1_wr_valid = 1; c1_wr_bits = 64'hDEAD;
    c0_wr_valid = 1; c0_wr_bits = 64'hBEEF;
    settle;
    chk("t3_wr_valid", mem_wr_valid, 1);
    chk("t3_wr_bits", mem_wr_bits, 64'hDEAD);
    chk("t3_c1_wr_ready", c1_wr_ready, 1);
    chk("t3_c0_wr_ready", c0_wr_ready, 0);
    tick;
    c1_wr_valid = 0;
    mem_rd_valid = 1; c0_rd_ready = 1;
    settle;
    chk("t3_done_busy", busy, 0);
    chk("ign_wr_ready", c0_wr_ready, 0);
    chk("ign_mem_wr", mem_wr_valid, 0);
    chk("ign_rd_ready", mem_rd_ready, 0);
    chk("ign_rd_valid", c0_rd_valid, 0);
    c0_wr_valid = 0; mem_rd_valid = 0; c0_rd_ready = 0;

    // c0 read len=1 with 3 stall cycles
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 1; c0_req_addr = 32'h80;
    settle;
    chk("t4_c0_ready", c0_req_ready, 1);
    tick;
    c0_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      mem_rd_valid = 1; mem_rd_bits = 64'h77; c0_rd_ready = 0;
      settle;
      chk("t4_stall_rdy", mem_rd_ready, 0);
      chk("t4_stall_busy", busy, 1);
    end
    tick;
    c0_rd_ready = 1;
    settle;
    chk("t4_rdy", mem_rd_ready, 1);
    tick;
    settle;
    chk("t4_beat2_busy", busy, 1);
    tick;
    mem_rd_valid = 0; c0_rd_ready = 0;
    settle;
    chk("t4_done", busy, 0);

    // reset mid-RD at beat 2 of 8
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 7;
    tick;
    c0_req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      mem_rd_valid = 1; c0_rd_ready = 1;
    end
    tick;
    reset = 0;
    settle;
    chk("t5_rst_rdvalid", c0_rd_valid, 0);
    chk("t5_rst_memrdy", mem_rd_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant, 0);
    tick;
    reset = 1; mem_rd_valid = 0; c0_rd_ready = 0;
    settle;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_grant", grant, 0);
    chk("t5_idle_memreq", mem_req_valid, 0);
    c0_req_valid = 1; c0_req_opcode = 1; c0_req_len = 8'hFF; c0_req_addr = 32'h1000;
    c1_req_valid = 1; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 32'h2000;
    settle;
    chk("t5_c0_wins", c0_req_ready, 1);
    chk("t5_c1_loses", c1_req_ready, 0);
    tick;
    c0_req_valid = 0;
    settle;
    chk("t6_len", mem_req_len, 8'hFF);

    // len=255 write: 256 beats, one stall in the middle
    for (int i = 0; i < 257; i++) begin
      tick;
      c0_wr_valid = (i != 100); c0_wr_bits = 64'(i);
      settle;
      chk("t6_busy", busy, 1);
      if (i != 100) chk("t6_wr_bits", mem_wr_bits, 64'(i));
    end
    tick;
    c0_wr_valid = 0;
    settle;
    chk("t6_done_busy", busy, 0);
    chk("t6_done_grant", grant, 0);
    chk("t6_c1_next", c1_req_ready, 1);
    c1_req_valid = 0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
